direction_cmd_gen: RTL and testbench
====================================

Name: direction_cmd_gen

Overview:
Upstream stage of the seven-segment direction display. It turns four raw direction push-buttons (R, L, B, F) into a clean, held 4-bit COMMAND vector in the bit order the display stage consumes: bit0 R, bit1 L, bit2 B, bit3 F. The block synchronises and debounces each button, and resolves opposing-pair conflicts. It also holds the last command for a programmable time after release so short taps stay visible on the display.

Parameters:
DB_CYCLES, 1000000, consecutive stable samples needed to accept a button level (10 ms at 100 MHz); must be >= 2
HOLD_CYCLES, 50000000, cycles the last non-zero command is held after all buttons release (0.5 s at 100 MHz); must be >= 1
CNT_W, 26, width of the debounce and hold counters; must hold max(DB_CYCLES, HOLD_CYCLES)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous active-low reset; 0 = in reset
BTN_R  in  1  raw right button, asynchronous, active-high
BTN_L  in  1  raw left button
BTN_B  in  1  raw back button
BTN_F  in  1  raw forward button
COMMAND  out  4  held direction command {F,B,L,R}; registered
CMD_VALID  out  1  one-cycle pulse on any cycle in which COMMAND changes value
HOLDING  out  1  high while in HOLD state

Behaviour:
- One clock domain: CLK. RESET is asynchronous and active-low. All flops clear immediately when RESET=0 and release on the first CLK edge with RESET=1.
- Reset values: COMMAND=4'b0000, CMD_VALID=0, HOLDING=0, FSM=IDLE, synchronisers=0, debounced levels=0, all counters=0.
- Synchroniser: each BTN_x passes through a 2-flop synchroniser before any other logic.
- Debounce, per button:
  - Counter cnt and accepted level db.
  - If the sync value equals db: cnt=0.
  - Otherwise cnt increments. When cnt reaches DB_CYCLES-1, db takes the sync value and cnt=0.
  - A glitch shorter than DB_CYCLES cycles never changes db.
- Pair resolution, combinational on db, giving res[3:0]:
  - If db_R and db_L are both 1, res[1:0]=00; else res[1:0]={db_L,db_R}.
  - The same rule applies to F/B on res[3:2].
  - Pairs are independent. R+F with no opposing button gives 4'b1001.
- FSM states:
  - IDLE: COMMAND=0. If res!=0, go to ACTIVE and load COMMAND<=res.
  - ACTIVE: COMMAND<=res every cycle while res!=0. If res==0, go to HOLD, load hold_cnt<=HOLD_CYCLES-1, and keep COMMAND unchanged.
  - HOLD: HOLDING=1.
    - If res!=0: go to ACTIVE and load COMMAND<=res (a new press cancels the hold).
    - Else if hold_cnt==0: go to IDLE and load COMMAND<=0.
    - Else hold_cnt decrements.
  - Unused encodings go to IDLE with COMMAND=0.
- CMD_VALID is registered. It is 1 for exactly one cycle, coincident with the first cycle the new COMMAND value is visible. It is never asserted when COMMAND is rewritten with an unchanged value.
- Latency: a clean press produces a COMMAND change 2 (sync) + DB_CYCLES + 1 (FSM register) cycles after the BTN edge. Release to COMMAND=0 takes 2 + DB_CYCLES + 1 + HOLD_CYCLES cycles.
- Boundary cases:
  - A press during the last hold cycle (hold_cnt==0 and res!=0 together): the press wins, COMMAND<=res, and there is no intermediate 0.
  - Conflicting pair pressed from idle: res=0, so the FSM stays in IDLE.
  - Reset mid-hold or mid-debounce: all state clears and COMMAND=0 at once (asynchronous).

Optional Feature:
Macro DIR_LAST_WINS_EN.
- Defined: for each pair, a 1-bit register records which member's db rose most recently; if both rise in the same cycle, R (resp. B) wins. When both members are held, res carries only the most recent one, e.g. hold R then press L gives res[1:0]=10. When one member releases, the other is reported.
- Undefined: the opposing pair cancels to 00 as specified above. The extra registers are not present.

Test Plan:
All scenarios use DB_CYCLES=4 and HOLD_CYCLES=8.
- Reset: RESET=0 with all buttons high -> COMMAND=0, CMD_VALID=0, HOLDING=0; after release with BTN_R held, COMMAND=4'b0001 at cycle 7 with a single CMD_VALID pulse.
- Glitch reject: BTN_F high for 3 cycles then low -> COMMAND stays 0, CMD_VALID never asserts.
- Hold timing: BTN_B pressed 20 cycles then released -> COMMAND=4'b0100 during HOLD, HOLDING=1 for 8 cycles, then COMMAND=0 with a CMD_VALID pulse.
- Conflict: BTN_R and BTN_L both held with BTN_F -> COMMAND=4'b1000. With DIR_LAST_WINS_EN defined, R first then L -> COMMAND=4'b1010.
- Re-press in hold: release R, press L at hold_cnt==0 -> COMMAND goes 0001 to 0010 directly with no 0000 cycle and one CMD_VALID pulse.
- Async reset mid-hold: RESET low between clock edges -> COMMAND=0 before the next CLK edge, FSM=IDLE.

Source files
------------

// File: rtl/direction_cmd_gen.sv
// direction_cmd_gen
// Turns four raw direction buttons into a held 4-bit command {F,B,L,R}.
// Path: 2-flop synchroniser -> per-button debounce -> opposing-pair resolution
// -> IDLE/ACTIVE/HOLD FSM. The FSM keeps the last command visible for
// HOLD_CYCLES after every button has been released.
// Optional feature, macro DIR_LAST_WINS_EN: when both members of an opposing
// pair are held, report the member pressed most recently instead of cancelling.
//
// state  | meaning
// IDLE   | nothing pressed, COMMAND = 0
// ACTIVE | resolved direction present, COMMAND follows res every cycle
// HOLD   | everything released, COMMAND frozen until hold_cnt runs out or a new press

module direction_cmd_gen #(
    parameter int DB_CYCLES   = 1000000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_R,
    input  logic       BTN_L,
    input  logic       BTN_B,
    input  logic       BTN_F,
    output logic [3:0] COMMAND,
    output logic       CMD_VALID,
    output logic       HOLDING
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [3:0]       btn_raw;
    logic [3:0]       sync_1;
    logic [3:0]       sync_2;
    logic [3:0]       db;
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       res;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_d;
    logic [3:0]       cmd_d;

    assign btn_raw = {BTN_F, BTN_B, BTN_L, BTN_R};

    // Two-flop synchroniser in front of everything else.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef DIR_LAST_WINS_EN
    logic [3:0] db_rise;
    logic       l_newer;   // 1: L rose after R
    logic       f_newer;   // 1: F rose after B

    // Debounced rising edges, i.e. the cycle in which db is about to go 0 -> 1.
    always_comb begin
        db_rise = '0;
        for (int i = 0; i < 4; i++) begin
            db_rise[i] = sync_2[i] && !db[i] && (db_cnt[i] == DB_LAST);
        end
    end

    // Remember which member of each pair was pressed last; simultaneous rise favours R / B.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            l_newer <= 1'b0;
            f_newer <= 1'b0;
        end else begin
            if (db_rise[0]) begin
                l_newer <= 1'b0;
            end else if (db_rise[1]) begin
                l_newer <= 1'b1;
            end
            if (db_rise[2]) begin
                f_newer <= 1'b0;
            end else if (db_rise[3]) begin
                f_newer <= 1'b1;
            end
        end
    end

    // Pair resolution: a fully held pair reports its most recent member.
    always_comb begin
        res = db;
        if (db[0] && db[1]) begin
            res[1:0] = l_newer ? 2'b10 : 2'b01;
        end
        if (db[2] && db[3]) begin
            res[3:2] = f_newer ? 2'b10 : 2'b01;
        end
    end
`else
    // Pair resolution: a fully held opposing pair cancels out.
    always_comb begin
        res = db;
        if (db[0] && db[1]) begin
            res[1:0] = 2'b00;
        end
        if (db[2] && db[3]) begin
            res[3:2] = 2'b00;
        end
    end
`endif

    // Next-state and next-command logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt;
        cmd_d   = COMMAND;
        case (state_q)
            IDLE: begin
                cmd_d = '0;
                if (res != 4'b0000) begin
                    state_d = ACTIVE;
                    cmd_d   = res;
                end
            end
            ACTIVE: begin
                if (res != 4'b0000) begin
                    cmd_d = res;
                end else begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (res != 4'b0000) begin
                    state_d = ACTIVE;
                    cmd_d   = res;
                end else if (hold_cnt == '0) begin
                    state_d = IDLE;
                    cmd_d   = '0;
                end else begin
                    hold_d = hold_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cmd_d   = '0;
            end
        endcase
    end

    // FSM and output registers; CMD_VALID flags a real change of COMMAND only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            hold_cnt  <= '0;
            COMMAND   <= '0;
            CMD_VALID <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_cnt  <= hold_d;
            COMMAND   <= cmd_d;
            CMD_VALID <= (cmd_d != COMMAND);
        end
    end

    assign HOLDING = (state_q == HOLD);

endmodule

// File: tb/tb_direction_cmd_gen.sv
// Testbench for direction_cmd_gen with DB_CYCLES=4, HOLD_CYCLES=8.
// Directed scenarios followed by randomized button sequences, all checked
// cycle by cycle against a timestamp-based reference model.
`timescale 1ns/1ps

module tb_direction_cmd_gen;

    localparam int DB   = 4;
    localparam int HOLD = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BTN_R = 1'b1;
    logic       BTN_L = 1'b1;
    logic       BTN_B = 1'b1;
    logic       BTN_F = 1'b1;
    logic [3:0] COMMAND;
    logic       CMD_VALID;
    logic       HOLDING;

    int n_checks = 0;
    int n_errors = 0;

    logic rst_drv = 1'b0;

    // window statistics for directed scenarios
    int valid_cnt;
    int zero_cnt;
    int nonzero_cnt;
    int holding_cnt;
    int hold_cmd_cnt;

    // reference model state
    int         n_edge = 0;
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic [3:0] m_db = '0;
    logic [3:0] m_cmd = '0;
    logic       m_valid = 1'b0;
    logic       m_holding = 1'b0;
    int         m_zero_run = 0;
    int         m_agree [4] = '{0, 0, 0, 0};
    int         m_rise [4]  = '{0, 0, 0, 0};

    direction_cmd_gen #(
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(HOLD),
        .CNT_W      (8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_R    (BTN_R),
        .BTN_L    (BTN_L),
        .BTN_B    (BTN_B),
        .BTN_F    (BTN_F),
        .COMMAND  (COMMAND),
        .CMD_VALID(CMD_VALID),
        .HOLDING  (HOLDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pair resolution from debounced levels and press timestamps.
    function automatic logic [3:0] model_res();
        logic [3:0] r;
        r = m_db;
`ifdef DIR_LAST_WINS_EN
        if (m_db[0] && m_db[1]) r[1:0] = (m_rise[1] > m_rise[0]) ? 2'b10 : 2'b01;
        if (m_db[2] && m_db[3]) r[3:2] = (m_rise[3] > m_rise[2]) ? 2'b10 : 2'b01;
`else
        if (m_db[0] && m_db[1]) r[1:0] = 2'b00;
        if (m_db[2] && m_db[3]) r[3:2] = 2'b00;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_db = '0;
        m_cmd = '0;
        m_valid = 1'b0;
        m_holding = 1'b0;
        m_zero_run = 0;
        for (int i = 0; i < 4; i++) begin
            m_agree[i] = n_edge;
            m_rise[i]  = 0;
        end
    endtask

    // One clock edge of the reference model.
    // COMMAND: current resolved value if non-zero; otherwise the previous
    // command survives until res has been zero for more than HOLD edges.
    // Debounce: a level is accepted once DB edges in a row saw the other level.
    task automatic model_edge();
        logic [3:0] res;
        logic [3:0] sp;
        logic [3:0] old;
        logic [3:0] nc;
        n_edge++;
        if (!RESET) begin
            model_reset();
        end else begin
            res = model_res();
            sp  = m_s2;
            old = m_cmd;
            if (res != 4'b0000) begin
                m_zero_run = 0;
                nc = res;
            end else begin
                m_zero_run++;
                nc = (m_zero_run > HOLD) ? 4'b0000 : old;
            end
            m_holding = (res == 4'b0000) && (old != 4'b0000) && (m_zero_run <= HOLD);
            m_valid   = (nc != old);
            m_cmd     = nc;
            for (int i = 0; i < 4; i++) begin
                if (sp[i] == m_db[i]) begin
                    m_agree[i] = n_edge;
                end else if (n_edge - m_agree[i] >= DB) begin
                    m_db[i]    = sp[i];
                    m_agree[i] = n_edge;
                    if (sp[i]) m_rise[i] = n_edge;
                end
            end
            m_s2 = m_s1;
            m_s1 = {BTN_F, BTN_B, BTN_L, BTN_R};
        end
    endtask

    task automatic clear_window();
        valid_cnt    = 0;
        zero_cnt     = 0;
        nonzero_cnt  = 0;
        holding_cnt  = 0;
        hold_cmd_cnt = 0;
    endtask

    // Drive buttons {F,B,L,R} and reset on the falling edge, advance one clock, compare.
    task automatic step(input logic [3:0] btn);
        @(negedge CLK);
        {BTN_F, BTN_B, BTN_L, BTN_R} = btn;
        RESET = rst_drv;
        @(posedge CLK);
        model_edge();
        #1;
        chk("command",   32'(COMMAND),   32'(m_cmd));
        chk("cmd_valid", 32'(CMD_VALID), 32'(m_valid));
        chk("holding",   32'(HOLDING),   32'(m_holding));
        if (CMD_VALID) valid_cnt++;
        if (COMMAND == 4'b0000) zero_cnt++;
        else nonzero_cnt++;
        if (HOLDING) holding_cnt++;
        if (HOLDING && COMMAND == 4'b0100) hold_cmd_cnt++;
    endtask

    initial begin
        int first_valid;
        int seg_len;
        logic [3:0] pat;

        clear_window();
        #1;
        chk("rst_command", 32'(COMMAND), 32'h0);
        chk("rst_valid",   32'(CMD_VALID), 32'h0);
        chk("rst_holding", 32'(HOLDING), 32'h0);

        // reset held with every button pressed
        for (int k = 0; k < 4; k++) step(4'b1111);

        // release reset with R held: change expected on the 7th edge
        rst_drv = 1'b1;
        clear_window();
        first_valid = 0;
        for (int k = 1; k <= 12; k++) begin
            step(4'b0001);
            if (CMD_VALID && first_valid == 0) first_valid = k;
        end
        chk("press_latency", 32'(first_valid), 32'd7);
        chk("press_pulses",  32'(valid_cnt), 32'd1);
        chk("press_cmd",     32'(COMMAND), 32'h1);
        for (int k = 0; k < 20; k++) step(4'b0000);

        // glitch of 3 cycles on F
        clear_window();
        for (int k = 0; k < 3; k++) step(4'b1000);
        for (int k = 0; k < 12; k++) step(4'b0000);
        chk("glitch_valid",   32'(valid_cnt), 32'd0);
        chk("glitch_nonzero", 32'(nonzero_cnt), 32'd0);

        // hold timing with B
        for (int k = 0; k < 20; k++) step(4'b0100);
        clear_window();
        for (int k = 0; k < 25; k++) step(4'b0000);
        chk("hold_holding_cycles", 32'(holding_cnt), 32'd8);
        chk("hold_cmd_during",     32'(hold_cmd_cnt), 32'd8);
        chk("hold_release_pulse",  32'(valid_cnt), 32'd1);
        chk("hold_final_cmd",      32'(COMMAND), 32'h0);

        // opposing pair conflict
`ifdef DIR_LAST_WINS_EN
        for (int k = 0; k < 12; k++) step(4'b1001);
        for (int k = 0; k < 12; k++) step(4'b1011);
        chk("conflict_last_wins", 32'(COMMAND), 32'ha);
`else
        for (int k = 0; k < 12; k++) step(4'b1011);
        chk("conflict_cancel", 32'(COMMAND), 32'h8);
`endif
        for (int k = 0; k < 20; k++) step(4'b0000);

        // re-press landing on the last hold cycle
        for (int k = 0; k < 12; k++) step(4'b0001);
        clear_window();
        for (int k = 0; k < 8; k++) step(4'b0000);
        for (int k = 0; k < 15; k++) step(4'b0010);
        chk("repress_zero_cycles", 32'(zero_cnt), 32'd0);
        chk("repress_pulses",      32'(valid_cnt), 32'd1);
        chk("repress_hold_cycles", 32'(holding_cnt), 32'd8);
        chk("repress_cmd",         32'(COMMAND), 32'h2);

        // asynchronous reset in the middle of a hold
        for (int k = 0; k < 12; k++) step(4'b0001);
        for (int k = 0; k < 10; k++) step(4'b0000);
        chk("pre_reset_holding", 32'(HOLDING), 32'h1);
        chk("pre_reset_cmd",     32'(COMMAND), 32'h1);
        #2;
        RESET = 1'b0;
        rst_drv = 1'b0;
        model_reset();
        #1;
        chk("async_rst_cmd",     32'(COMMAND), 32'h0);
        chk("async_rst_holding", 32'(HOLDING), 32'h0);
        chk("async_rst_valid",   32'(CMD_VALID), 32'h0);
        for (int k = 0; k < 3; k++) step(4'b0000);
        rst_drv = 1'b1;
        for (int k = 0; k < 3; k++) step(4'b0000);

        // randomized sequences
        for (int s = 0; s < 160; s++) begin
            pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) pat = 4'b0000;
            seg_len = $urandom_range(1, 18);
            for (int k = 0; k < seg_len; k++) step(pat);
        end
        for (int k = 0; k < 20; k++) step(4'b0000);
        chk("final_idle_cmd", 32'(COMMAND), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
